wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Writeback arbiter and scoreboard sitting directly upstream of the register file write port in the RISC-V core.
- Merges two writeback sources into the single regfile write port (we/wa/wd):
  - the single-cycle datapath result (fixed priority, no backpressure);
  - a long-latency source such as the load/store unit or mul/div (valid/ready handshake, buffered in a small FIFO).
- Tracks registers with outstanding long-latency writes and raises a hazard stall toward decode.

Parameters:
- XLEN, 32, data width of writeback values.
- FIFO_DEPTH, 4, entries in long-latency writeback FIFO; power of two, >= 2.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- pipe_we  in  1  single-cycle datapath write request.
- pipe_wa  in  5  its destination register.
- pipe_wd  in  XLEN  its write data.
- ll_valid  in  1  long-latency result valid.
- ll_ready  out  1  arbiter can accept a long-latency result.
- ll_wa  in  5  long-latency destination register.
- ll_wd  in  XLEN  long-latency write data.
- iss_valid  in  1  a long-latency op is being issued this cycle.
- iss_rd  in  5  destination of the issued op.
- dec_ra1  in  5  decode source register 1.
- dec_ra2  in  5  decode source register 2.
- dec_rd  in  5  decode destination register.
- hz_stall  out  1  decode must stall (RAW/WAW on pending register).
- rf_we  out  1  regfile write enable.
- rf_wa  out  5  regfile write address.
- rf_wd  out  XLEN  regfile write data.
- sb_err  out  1  sticky scoreboard protocol error.

Behaviour:
- Reset (rst=1 at posedge): FIFO empty, pending mask all 0, sb_err=0. While rst is high: ll_ready=0, rf_we=0, hz_stall=0. Reset mid-transfer drops all buffered entries and pending bits without writing them.
- Write selection (combinational, same cycle):
  - If pipe_we=1 and pipe_wa!=0: rf_we=1 with pipe_wa/pipe_wd.
  - Else if FIFO non-empty: rf_we=1 with head entry; head pops at the clock edge.
  - Else rf_we=0; rf_wa=0 and rf_wd=0 when rf_we=0.
  - pipe_we with pipe_wa=0 counts as no write and does not block the FIFO.
- Long-latency acceptance:
  - ll_ready = !full (registered count; a same-cycle pop does not free a slot).
  - Transfer when ll_valid && ll_ready; entry enqueued at the edge, earliest regfile write the next cycle.
  - ll_wa=0 transfers complete the handshake and are discarded (not enqueued).
  - Simultaneous push and pop: count unchanged; FIFO order preserved.
- Scoreboard (32-bit pending mask; bit 0 never set):
  - iss_valid with iss_rd!=0 sets pend[iss_rd] at the edge.
  - A FIFO entry written to the regfile clears pend[wa] at the edge.
  - Set and clear of the same register in one cycle: set wins.
- Hazard and error reporting:
  - hz_stall = pend[dec_ra1] | pend[dec_ra2] | pend[dec_rd], each term masked when its index is 0; combinational from registered pend.
  - sb_err sets (sticky until rst) on any of:
    - iss_valid to an already-pending rd without a same-cycle clear;
    - pipe_we to a pending register;
    - FIFO write whose register is not pending.

Optional Feature:
- Macro WB_LL_BYPASS_EN.
- Defined: when FIFO empty and no valid pipe write this cycle, an accepted ll_valid with ll_wa!=0 drives rf_we/rf_wa/rf_wd combinationally in the same cycle, is not enqueued, and clears pend[ll_wa] at the edge (zero-latency path).
- Undefined: all long-latency results pass through the FIFO (minimum 1-cycle latency).

Test Plan:
- Reset then idle -> rf_we=0, ll_ready=1, hz_stall=0, sb_err=0.
- pipe_we=1 wa=5 wd=0xDEADBEEF -> same cycle rf_we=1 rf_wa=5 rf_wd=0xDEADBEEF; pipe_wa=0 -> rf_we=0.
- iss_valid rd=7; dec_ra1=7 -> hz_stall=1. ll push wa=7 wd=0x12345678 (bypass off) -> regfile write on next cycle, hz_stall=0 the cycle after.
- pipe_we=1 every cycle while 4 ll results pushed (regs 1..4 pending) -> ll_ready=0 after 4th; pipe drops -> writes 1,2,3,4 in order, one per cycle; pend clears in order.
- iss rd=9 twice without writeback -> sb_err=1, stays 1 until rst; ll_wa=0 push -> accepted, no rf_we.
- rst asserted with 3 entries queued -> next cycle FIFO empty, pend=0, no rf writes of dropped entries.

Source files
------------

// File: rtl/wb_arbiter.sv
// Writeback arbiter and pending-register scoreboard in front of the regfile write port.
// Optional zero-latency long-latency path enabled by defining WB_LL_BYPASS_EN.
module wb_arbiter #(
    parameter int XLEN       = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pipe_we,
    input  logic [4:0]      pipe_wa,
    input  logic [XLEN-1:0] pipe_wd,
    input  logic            ll_valid,
    output logic            ll_ready,
    input  logic [4:0]      ll_wa,
    input  logic [XLEN-1:0] ll_wd,
    input  logic            iss_valid,
    input  logic [4:0]      iss_rd,
    input  logic [4:0]      dec_ra1,
    input  logic [4:0]      dec_ra2,
    input  logic [4:0]      dec_rd,
    output logic            hz_stall,
    output logic            rf_we,
    output logic [4:0]      rf_wa,
    output logic [XLEN-1:0] rf_wd,
    output logic            sb_err
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      pend_q, pend_d;
    logic [31:0]      set_vec, clr_vec;
    logic             sb_err_q, sb_err_d;

    logic [4:0]      fifo_wa_mem [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_wd_mem [FIFO_DEPTH];

    logic            fifo_empty, fifo_full;
    logic            pipe_wr, fifo_pop, ll_fire, ll_push, byp_wr;
    logic [4:0]      head_wa;
    logic [XLEN-1:0] head_wd;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign head_wa    = fifo_wa_mem[rd_ptr_q];
    assign head_wd    = fifo_wd_mem[rd_ptr_q];

    // A pipe write to x0 is no write at all and must not starve the FIFO.
    assign pipe_wr  = !rst && pipe_we && (pipe_wa != 5'd0);
    assign fifo_pop = !rst && !pipe_wr && !fifo_empty;
    assign ll_ready = !rst && !fifo_full;
    assign ll_fire  = ll_valid && ll_ready && (ll_wa != 5'd0);

`ifdef WB_LL_BYPASS_EN
    assign byp_wr = ll_fire && fifo_empty && !pipe_wr;
`else
    assign byp_wr = 1'b0;
`endif
    assign ll_push = ll_fire && !byp_wr;

    always_comb begin
        rf_we = 1'b0;
        rf_wa = 5'd0;
        rf_wd = '0;
        if (pipe_wr) begin
            rf_we = 1'b1;
            rf_wa = pipe_wa;
            rf_wd = pipe_wd;
        end else if (fifo_pop) begin
            rf_we = 1'b1;
            rf_wa = head_wa;
            rf_wd = head_wd;
        end else if (byp_wr) begin
            rf_we = 1'b1;
            rf_wa = ll_wa;
            rf_wd = ll_wd;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_pend
            assign set_vec[gi] = (gi != 0) && iss_valid && (iss_rd == 5'(gi));
            assign clr_vec[gi] = (fifo_pop && (head_wa == 5'(gi)))
                              || (byp_wr && (ll_wa == 5'(gi)));
        end
    endgenerate

    always_comb begin
        pend_d    = (pend_q & ~clr_vec) | set_vec;
        pend_d[0] = 1'b0;

        sb_err_d = sb_err_q;
        if (iss_valid && (iss_rd != 5'd0) && pend_q[iss_rd] && !clr_vec[iss_rd])
            sb_err_d = 1'b1;
        if (pipe_wr && pend_q[pipe_wa])
            sb_err_d = 1'b1;
        if ((fifo_pop && !pend_q[head_wa]) || (byp_wr && !pend_q[ll_wa]))
            sb_err_d = 1'b1;

        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (fifo_pop)
            rd_ptr_d = rd_ptr_q + 1'b1;
        if (ll_push)
            wr_ptr_d = wr_ptr_q + 1'b1;
        case ({ll_push, fifo_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            pend_q   <= '0;
            sb_err_q <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            pend_q   <= pend_d;
            sb_err_q <= sb_err_d;
        end
    end

    // Payload storage carries no reset; validity lives entirely in count_q.
    always_ff @(posedge clk) begin
        if (ll_push) begin
            fifo_wa_mem[wr_ptr_q] <= ll_wa;
            fifo_wd_mem[wr_ptr_q] <= ll_wd;
        end
    end

    assign hz_stall = !rst && (((dec_ra1 != 5'd0) && pend_q[dec_ra1])
                            || ((dec_ra2 != 5'd0) && pend_q[dec_ra2])
                            || ((dec_rd  != 5'd0) && pend_q[dec_rd]));
    assign sb_err   = sb_err_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter; expectations are hand-computed per cycle.
module tb_wb_arbiter;
    localparam int XLEN = 32;
`ifdef WB_LL_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            pipe_we;
    logic [4:0]      pipe_wa;
    logic [XLEN-1:0] pipe_wd;
    logic            ll_valid;
    logic            ll_ready;
    logic [4:0]      ll_wa;
    logic [XLEN-1:0] ll_wd;
    logic            iss_valid;
    logic [4:0]      iss_rd;
    logic [4:0]      dec_ra1, dec_ra2, dec_rd;
    logic            hz_stall;
    logic            rf_we;
    logic [4:0]      rf_wa;
    logic [XLEN-1:0] rf_wd;
    logic            sb_err;

    int checks = 0;
    int errors = 0;

    wb_arbiter #(.XLEN(XLEN), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .pipe_we(pipe_we), .pipe_wa(pipe_wa), .pipe_wd(pipe_wd),
        .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_wa(ll_wa), .ll_wd(ll_wd),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .dec_ra1(dec_ra1), .dec_ra2(dec_ra2), .dec_rd(dec_rd),
        .hz_stall(hz_stall),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Advance past the next rising edge; inputs are then changed and settled before checking.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pipe_we = 0; pipe_wa = 0; pipe_wd = 0;
        ll_valid = 0; ll_wa = 0; ll_wd = 0;
        iss_valid = 0; iss_rd = 0;
        dec_ra1 = 0; dec_ra2 = 0; dec_rd = 0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        tick();
        // Inputs requesting activity while in reset must be suppressed.
        pipe_we = 1; pipe_wa = 3; ll_valid = 1; ll_wa = 4;
        #1;
        chk("rst_ll_ready", ll_ready, 0);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_hz_stall", hz_stall, 0);
        idle();
        tick();
        rst = 1'b0;
        #1;
        chk("idle_rf_we", rf_we, 0);
        chk("idle_ll_ready", ll_ready, 1);
        chk("idle_hz_stall", hz_stall, 0);
        chk("idle_sb_err", sb_err, 0);

        // Pipe write passes through in the same cycle; x0 is not a write.
        pipe_we = 1; pipe_wa = 5; pipe_wd = 32'hDEADBEEF;
        #1;
        chk("pipe_rf_we", rf_we, 1);
        chk("pipe_rf_wa", rf_wa, 5);
        chk("pipe_rf_wd", rf_wd, 32'hDEADBEEF);
        pipe_wa = 0;
        #1;
        chk("pipe_x0_rf_we", rf_we, 0);
        chk("pipe_x0_rf_wa", rf_wa, 0);
        chk("pipe_x0_rf_wd", rf_wd, 0);
        idle();

        // Issue to x7, stall on it, then return the result through the FIFO.
        tick();
        iss_valid = 1; iss_rd = 7;
        tick();
        idle();
        dec_ra1 = 7;
        ll_valid = 1; ll_wa = 7; ll_wd = 32'h12345678;
        #1;
        chk("r7_hz_pending", hz_stall, 1);
        chk("r7_ll_ready", ll_ready, 1);
        chk("r7_push_rf_we", rf_we, BYP);
        tick();
        ll_valid = 0; ll_wa = 0; ll_wd = 0;
        #1;
        chk("r7_wb_rf_we", rf_we, !BYP);
        chk("r7_wb_rf_wa", rf_wa, BYP ? 0 : 7);
        chk("r7_wb_rf_wd", rf_wd, BYP ? 0 : 32'h12345678);
        chk("r7_wb_hz", hz_stall, !BYP);
        tick();
        chk("r7_after_hz", hz_stall, 0);
        chk("r7_after_rf_we", rf_we, 0);
        idle();

        // Mark x1..x4 pending, then fill the FIFO while the pipe owns the port.
        for (int k = 1; k <= 4; k++) begin
            iss_valid = 1; iss_rd = 5'(k);
            tick();
        end
        idle();
        for (int k = 1; k <= 4; k++) begin
            pipe_we = 1; pipe_wa = 20; pipe_wd = 32'h2000 + k;
            ll_valid = 1; ll_wa = 5'(k); ll_wd = 32'h1111 * k;
            #1;
            chk($sformatf("fill%0d_ll_ready", k), ll_ready, 1);
            chk($sformatf("fill%0d_rf_wa", k), rf_wa, 20);
            tick();
        end
        idle();
        #1;
        chk("full_ll_ready", ll_ready, 0);
        for (int k = 1; k <= 4; k++) begin
            // An x0 pipe write mid-drain must not block the head.
            pipe_we = (k == 2); pipe_wa = 0;
            dec_ra1 = 5'(k);
            #1;
            chk($sformatf("drain%0d_rf_we", k), rf_we, 1);
            chk($sformatf("drain%0d_rf_wa", k), rf_wa, k);
            chk($sformatf("drain%0d_rf_wd", k), rf_wd, 32'h1111 * k);
            chk($sformatf("drain%0d_hz", k), hz_stall, 1);
            if (k == 1) chk("drain1_ll_ready", ll_ready, 0);
            tick();
        end
        idle();
        dec_ra1 = 1; dec_ra2 = 2; dec_rd = 4;
        #1;
        chk("drained_rf_we", rf_we, 0);
        chk("drained_hz", hz_stall, 0);
        chk("drained_ll_ready", ll_ready, 1);
        chk("drained_sb_err", sb_err, 0);
        idle();

        // ll_wa = 0 completes the handshake but writes nothing.
        ll_valid = 1; ll_wa = 0; ll_wd = 32'hBAD0;
        #1;
        chk("x0ll_ll_ready", ll_ready, 1);
        chk("x0ll_rf_we", rf_we, 0);
        tick();
        idle();
        #1;
        chk("x0ll_next_rf_we", rf_we, 0);

        // Double issue to x9 is a protocol error and sticks.
        iss_valid = 1; iss_rd = 9;
        tick();
        chk("iss9_once_sb_err", sb_err, 0);
        tick();
        idle();
        chk("iss9_twice_sb_err", sb_err, 1);
        tick();
        tick();
        chk("sb_err_sticky", sb_err, 1);

        // Queue three entries, then reset mid-flight.
        for (int k = 10; k <= 12; k++) begin
            iss_valid = 1; iss_rd = 5'(k);
            tick();
        end
        idle();
        for (int k = 10; k <= 12; k++) begin
            pipe_we = 1; pipe_wa = 21; pipe_wd = 0;
            ll_valid = 1; ll_wa = 5'(k); ll_wd = 32'h3000 + k;
            tick();
        end
        idle();
        rst = 1'b1;
        dec_ra1 = 10; dec_ra2 = 11; dec_rd = 12;
        #1;
        chk("midrst_rf_we", rf_we, 0);
        chk("midrst_ll_ready", ll_ready, 0);
        chk("midrst_hz", hz_stall, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("postrst_rf_we", rf_we, 0);
        chk("postrst_hz", hz_stall, 0);
        chk("postrst_sb_err", sb_err, 0);
        chk("postrst_ll_ready", ll_ready, 1);
        tick();
        chk("postrst2_rf_we", rf_we, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
